// File: rtl/decoder_act_monitor_if.sv
// Bundle of decoder inputs and activity-monitor results.
// master drives select/handshake; slave returns decode and counts.
interface decoder_act_monitor_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
);
  localparam int OUT_W = 1 << SEL_W;

  logic             en;
  logic [SEL_W-1:0] in;
  logic             in_valid;
  logic             start;
  logic             ack;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] out_toggles;
  logic [CNT_W-1:0] in_toggles;
  logic             sat;

  modport master (
    output en, in, in_valid, start, ack,
    input  out, out_valid, busy, done,
    input  out_toggles, in_toggles, sat
  );

  modport slave (
    input  en, in, in_valid, start, ack,
    output out, out_valid, busy, done,
    output out_toggles, in_toggles, sat
  );
endinterface

// File: rtl/decoder_act_monitor.sv
// Registered one-hot decoder with windowed toggle counters.
// Ports: clk, rst_n (async low), bus (decoder_act_monitor_if.slave).
module decoder_act_monitor #(
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16,
  parameter int WIN_LEN = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_act_monitor_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W:0]   CMAX = {1'b0, {CNT_W{1'b1}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] otog;
  logic [CNT_W-1:0] itog;
  logic             satq;
  logic [OUT_W-1:0] outq;
  logic [OUT_W-1:0] out_nx;
  logic             vq;
  logic [SEL_W-1:0] prev;

  logic             take;
  logic [CNT_W:0]   o_sum;
  logic [CNT_W:0]   i_sum;
  logic [CNT_W:0]   i_inc;
  logic             o_ov;
  logic             i_ov;

  assign take = bus.in_valid & bus.en;

  always_comb begin
    out_nx = outq;
    if (take)
      out_nx = OUT_W'(1) << bus.in;
    else if (bus.in_valid)
      out_nx = '0;
  end

  // One extra bit on each sum exposes the overflow.
  always_comb begin
    i_inc = '0;
    if (take)
      i_inc = (CNT_W+1)'($countones(bus.in ^ prev));
    o_sum = {1'b0, otog}
          + (CNT_W+1)'($countones(out_nx ^ outq));
    i_sum = {1'b0, itog} + i_inc;
    o_ov  = o_sum > CMAX;
    i_ov  = i_sum > CMAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outq <= '0;
      vq   <= 1'b0;
      prev <= '0;
    end else begin
      outq <= out_nx;
      vq   <= bus.in_valid;
      if (take)
        prev <= bus.in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cyc   <= '0;
      otog  <= '0;
      itog  <= '0;
      satq  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RUN;
            cyc   <= '0;
            otog  <= '0;
            itog  <= '0;
            satq  <= 1'b0;
          end
        end
        S_RUN: begin
          otog <= o_ov ? '1 : o_sum[CNT_W-1:0];
          itog <= i_ov ? '1 : i_sum[CNT_W-1:0];
          if (o_ov || i_ov)
            satq <= 1'b1;
          cyc <= cyc + 1'b1;
          if (cyc == LAST)
            state <= S_DONE;
        end
        S_DONE: begin
          if (bus.ack)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out         = outq;
  assign bus.out_valid   = vq;
  assign bus.busy        = (state == S_RUN);
  assign bus.done        = (state == S_DONE);
  assign bus.out_toggles = otog;
  assign bus.in_toggles  = itog;
  assign bus.sat         = satq;
endmodule
